// File: rtl/patch_kernel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : patch_kernel_scheduler
//  Purpose  : Job sequencer in front of the makePatches_ShadowQuilt_fromEdges
//             HLS kernel. Accepts job requests, drives the kernel block-level
//             ap_start/ap_ready/ap_done/ap_continue handshake with up to
//             MAX_OUT jobs in flight, and returns one completion record per
//             finished job (ID + start-to-done latency). A watchdog flags a
//             hung kernel; an ap_done with nothing outstanding is also flagged.
//  Ports    : clk, rst_n                 clock, synchronous active-low reset
//             i_req_valid/i_req_id/o_req_ready     job request port
//             o_ap_start/i_ap_ready/i_ap_done/o_ap_continue  kernel handshake
//             o_cpl_valid/o_cpl_id/o_cpl_cycles/i_cpl_ready  completion port
//             o_busy, o_jobs_done, o_err           status
//  Revision : 1.0  initial release
// ============================================================================
module patch_kernel_scheduler #(
    parameter int ID_W    = 4,
    parameter int MAX_OUT = 2,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid,
    input  logic [ID_W-1:0]  i_req_id,
    output logic             o_req_ready,
    output logic             o_ap_start,
    input  logic             i_ap_ready,
    input  logic             i_ap_done,
    output logic             o_ap_continue,
    output logic             o_cpl_valid,
    output logic [ID_W-1:0]  o_cpl_id,
    output logic [CNT_W-1:0] o_cpl_cycles,
    input  logic             i_cpl_ready,
    output logic             o_busy,
    output logic [31:0]      o_jobs_done,
    output logic [1:0]       o_err
);

    // A depth-1 FIFO still gets a 1-bit pointer; the occupancy limit keeps
    // it from ever holding more than MAX_OUT entries.
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int DEPTH = 1 << PTR_W;
    localparam int OCC_W = $clog2(MAX_OUT + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [OCC_W-1:0] c_MAX_OCC  = OCC_W'(MAX_OUT);
    localparam logic [WD_W-1:0]  c_WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_START = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_now;
    logic [ID_W-1:0]    r_pend_id;
    logic [CNT_W-1:0]   r_stamp;
    logic [ID_W-1:0]    r_fifo_id    [DEPTH];
    logic [CNT_W-1:0]   r_fifo_stamp [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [OCC_W-1:0]   r_occ;
    logic [WD_W-1:0]    r_wdog;
    logic               r_cpl_valid;
    logic [ID_W-1:0]    r_cpl_id;
    logic [CNT_W-1:0]   r_cpl_cycles;
    logic [31:0]        r_jobs_done;
    logic [1:0]         r_err;

    logic               w_ap_continue;
    logic               w_req_ready;
    logic               w_req_fire;
    logic               w_push;
    logic               w_done_fire;
    logic               w_pop;
    logic               w_spurious;
    logic [WD_W-1:0]    w_wdog_nxt;

    assign w_ap_continue = !r_cpl_valid || i_cpl_ready;
    // Gated by rst_n so no request is taken while reset is held.
    assign w_req_ready   = rst_n && (r_state == S_IDLE) && (r_occ < c_MAX_OCC)
                           && (r_err == 2'b00);
    assign w_req_fire    = i_req_valid && w_req_ready;
    assign w_push        = (r_state == S_START) && i_ap_ready;
    assign w_done_fire   = i_ap_done && w_ap_continue;
    assign w_pop         = w_done_fire && (r_occ != '0);
    assign w_spurious    = w_done_fire && (r_occ == '0);

    always_comb begin
        w_wdog_nxt = r_wdog;
        if ((r_occ == '0) || w_pop) begin
            w_wdog_nxt = '0;
        end else if (r_wdog != c_WD_LIMIT) begin
            w_wdog_nxt = r_wdog + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_now        <= '0;
            r_pend_id    <= '0;
            r_stamp      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
            r_wdog       <= '0;
            r_cpl_valid  <= 1'b0;
            r_cpl_id     <= '0;
            r_cpl_cycles <= '0;
            r_jobs_done  <= '0;
            r_err        <= 2'b00;
        end else begin
            r_now <= r_now + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_req_fire) begin
                        r_state   <= S_START;
                        r_pend_id <= i_req_id;
                        // Stamp is the timestamp of the first START cycle.
                        r_stamp   <= r_now + 1'b1;
                    end
                end
                S_START: begin
                    if (i_ap_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase

            r_wdog <= w_wdog_nxt;
            if ((r_occ != '0) && (w_wdog_nxt == c_WD_LIMIT)) begin
                r_err[0] <= 1'b1;
            end
            if (w_spurious) begin
                r_err[1] <= 1'b1;
            end

            // Pop only happens when the completion slot is free or being
            // drained this cycle, so a load here never overwrites a record.
            if (w_pop) begin
                r_cpl_valid  <= 1'b1;
                r_cpl_id     <= r_fifo_id[r_rd_ptr];
                r_cpl_cycles <= r_now - r_fifo_stamp[r_rd_ptr];
                r_jobs_done  <= r_jobs_done + 32'd1;
            end else if (i_cpl_ready) begin
                r_cpl_valid  <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_id[r_wr_ptr]    <= r_pend_id;
            r_fifo_stamp[r_wr_ptr] <= r_stamp;
        end
    end

    assign o_req_ready   = w_req_ready;
    assign o_ap_start    = (r_state == S_START);
    assign o_ap_continue = w_ap_continue;
    assign o_cpl_valid   = r_cpl_valid;
    assign o_cpl_id      = r_cpl_id;
    assign o_cpl_cycles  = r_cpl_cycles;
    assign o_busy        = (r_state == S_START) || (r_occ != '0);
    assign o_jobs_done   = r_jobs_done;
    assign o_err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_patch_kernel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_patch_kernel_scheduler
//  Purpose  : Self-checking bench for patch_kernel_scheduler. A queue-based
//             reference model predicts every output each cycle; directed
//             sequences plus a randomized kernel/consumer exercise the block.
//  Revision : 1.0  initial release
// ============================================================================
module tb_patch_kernel_scheduler;

    localparam int ID_W     = 4;
    localparam int MAX_OUT  = 2;
    localparam int CNT_W    = 8;
    localparam int TIMEOUT  = 50;
    localparam int CNT_MASK = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic [ID_W-1:0]  req_id;
    logic             req_ready;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic             cpl_valid;
    logic [ID_W-1:0]  cpl_id;
    logic [CNT_W-1:0] cpl_cycles;
    logic             cpl_ready;
    logic             busy;
    logic [31:0]      jobs_done;
    logic [1:0]       err;

    patch_kernel_scheduler #(
        .ID_W    (ID_W),
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (req_valid),
        .i_req_id      (req_id),
        .o_req_ready   (req_ready),
        .o_ap_start    (ap_start),
        .i_ap_ready    (ap_ready),
        .i_ap_done     (ap_done),
        .o_ap_continue (ap_continue),
        .o_cpl_valid   (cpl_valid),
        .o_cpl_id      (cpl_id),
        .o_cpl_cycles  (cpl_cycles),
        .i_cpl_ready   (cpl_ready),
        .o_busy        (busy),
        .o_jobs_done   (jobs_done),
        .o_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct {
        int id;
        int stamp;
    } job_t;

    job_t m_q[$];
    int   m_now;
    bit   m_start;
    int   m_pend_id;
    int   m_stamp;
    bit   m_cpl_valid;
    int   m_cpl_id;
    int   m_cpl_cycles;
    int   m_jobs;
    int   m_err;
    int   m_stall;      // consecutive cycles with jobs outstanding and no pop
    bit   m_ad_held;    // kernel must keep ap_done until it is accepted
    bit   m_fire;

    int   n_checks;
    int   n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_now        = 0;
        m_start      = 0;
        m_pend_id    = 0;
        m_stamp      = 0;
        m_cpl_valid  = 0;
        m_cpl_id     = 0;
        m_cpl_cycles = 0;
        m_jobs       = 0;
        m_err        = 0;
        m_stall      = 0;
        m_ad_held    = 0;
        m_fire       = 0;
    endtask

    task automatic check_outputs();
        bit exp_ready;
        exp_ready = rst_n && !m_start && (m_q.size() < MAX_OUT) && (m_err == 0);
        check_eq("req_ready",   32'(req_ready),   32'(exp_ready));
        check_eq("ap_start",    32'(ap_start),    32'(m_start));
        check_eq("ap_continue", 32'(ap_continue), 32'(!m_cpl_valid || cpl_ready));
        check_eq("busy",        32'(busy),        32'(m_start || (m_q.size() != 0)));
        check_eq("cpl_valid",   32'(cpl_valid),   32'(m_cpl_valid));
        check_eq("cpl_id",      32'(cpl_id),      32'(m_cpl_id));
        check_eq("cpl_cycles",  32'(cpl_cycles),  32'(m_cpl_cycles));
        check_eq("jobs_done",   jobs_done,        32'(m_jobs));
        check_eq("err",         32'(err),         32'(m_err));
    endtask

    // One clock: drive inputs, advance the model, then check at the next negedge.
    task automatic cycle(input bit rv, input int rid, input bit ar, input bit ad,
                         input bit cr, input bit rn);
        bit   pred_ready, push, cont, dfire, pop;
        job_t e;
        int   rid_v;
        rid_v     = rid;
        rst_n     = rn;
        req_valid = rv;
        req_id    = rid_v[ID_W-1:0];
        ap_ready  = ar;
        ap_done   = ad;
        cpl_ready = cr;
        if (!rn) begin
            model_reset();
        end else begin
            pred_ready = !m_start && (m_q.size() < MAX_OUT) && (m_err == 0);
            m_fire = rv && pred_ready;
            push   = m_start && ar;
            cont   = !m_cpl_valid || cr;
            dfire  = ad && cont;
            pop    = dfire && (m_q.size() > 0);
            if (dfire && (m_q.size() == 0)) m_err |= 2;
            if ((m_q.size() == 0) || pop) m_stall = 0;
            else if (m_stall < TIMEOUT) m_stall++;
            if (m_stall == TIMEOUT) m_err |= 1;
            if (pop) begin
                e            = m_q.pop_front();
                m_cpl_valid  = 1;
                m_cpl_id     = e.id;
                m_cpl_cycles = (m_now - e.stamp) & CNT_MASK;
                m_jobs++;
            end else if (cr) begin
                m_cpl_valid = 0;
            end
            if (push) begin
                m_q.push_back('{m_pend_id, m_stamp});
                m_start = 0;
            end
            if (m_fire) begin
                m_start   = 1;
                m_pend_id = rid_v & ((1 << ID_W) - 1);
                m_stamp   = (m_now + 1) & CNT_MASK;
            end
            m_now     = (m_now + 1) & CNT_MASK;
            m_ad_held = ad && !dfire;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 1, 1);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        idle();
    endtask

    // Request accepted this cycle, kernel takes it on the next.
    task automatic start_job(input int id);
        cycle(1, id, 0, 0, 1, 1);
        cycle(0, 0, 1, 0, 1, 1);
    endtask

    initial begin
        int ids[3];
        int k;
        bit rn, rv, ar, ad, cr;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_id    = '0;
        ap_ready  = 1'b0;
        ap_done   = 1'b0;
        cpl_ready = 1'b1;
        model_reset();
        @(negedge clk);
        check_outputs();
        do_reset();

        // ---- single job: ready at T+1, done at T+21 -> latency 20 ----
        cycle(1, 3, 0, 0, 1, 1);
        check_eq("single_ap_start_T1", 32'(ap_start), 32'd1);
        cycle(0, 0, 1, 0, 1, 1);
        check_eq("single_ap_start_T2", 32'(ap_start), 32'd0);
        repeat (19) idle();
        cycle(0, 0, 0, 1, 1, 1);
        check_eq("single_cpl_valid",  32'(cpl_valid),  32'd1);
        check_eq("single_cpl_id",     32'(cpl_id),     32'd3);
        check_eq("single_cpl_cycles", 32'(cpl_cycles), 32'd20);
        check_eq("single_jobs_done",  jobs_done,       32'd1);
        check_eq("single_busy",       32'(busy),       32'd0);
        idle();

        // ---- back-to-back requests, kernel never done ----
        ids = '{1, 2, 3};
        k   = 0;
        repeat (8) begin
            cycle(1, ids[k], m_start, 0, 1, 1);
            if (m_fire && k < 2) k++;
        end
        check_eq("b2b_req_ready_full", 32'(req_ready), 32'd0);
        cycle(1, 3, 0, 1, 1, 1);
        check_eq("b2b_first_cpl", 32'(cpl_id), 32'd1);
        cycle(1, 3, 0, 1, 1, 1);
        check_eq("b2b_second_cpl", 32'(cpl_id), 32'd2);
        cycle(0, 0, 1, 0, 1, 1);
        cycle(0, 0, 0, 1, 1, 1);
        check_eq("b2b_third_cpl", 32'(cpl_id), 32'd3);
        idle();

        // ---- completion backpressure ----
        start_job(5);
        start_job(6);
        cycle(0, 0, 0, 1, 1, 1);
        repeat (3) begin
            cycle(0, 0, 0, 1, 0, 1);
            check_eq("bp_ap_continue", 32'(ap_continue), 32'd0);
            check_eq("bp_cpl_hold",    32'(cpl_id),      32'd5);
        end
        cycle(0, 0, 0, 1, 1, 1);
        check_eq("bp_next_valid", 32'(cpl_valid), 32'd1);
        check_eq("bp_next_id",    32'(cpl_id),    32'd6);
        idle();

        // ---- simultaneous push and pop ----
        start_job(7);
        cycle(1, 8, 0, 0, 1, 1);
        cycle(0, 0, 1, 1, 1, 1);
        check_eq("pp_cpl_id", 32'(cpl_id), 32'd7);
        check_eq("pp_busy",   32'(busy),   32'd1);
        cycle(0, 0, 0, 1, 1, 1);
        check_eq("pp_cpl_id2", 32'(cpl_id), 32'd8);
        check_eq("pp_busy2",   32'(busy),   32'd0);
        idle();

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 2500; i++) begin
            rn = ($urandom_range(399) != 0);
            rv = $urandom_range(1) != 0;
            ar = m_start && ($urandom_range(2) == 0);
            ad = m_ad_held || ((m_q.size() > 0) && ($urandom_range(3) == 0));
            cr = ($urandom_range(3) != 0);
            cycle(rv, int'($urandom_range(15)), ar, ad, cr, rn);
        end

        // ---- watchdog timeout ----
        do_reset();
        start_job(9);
        repeat (TIMEOUT - 1) idle();
        check_eq("wd_before_limit", 32'(err), 32'd0);
        repeat (3) idle();
        check_eq("wd_err", 32'(err), 32'd1);
        cycle(1, 2, 0, 0, 1, 1);
        check_eq("wd_no_start", 32'(ap_start), 32'd0);

        // ---- spurious ap_done ----
        do_reset();
        start_job(4);
        cycle(0, 0, 0, 1, 1, 1);
        idle();
        cycle(0, 0, 0, 1, 1, 1);
        check_eq("spur_err",       32'(err),       32'd2);
        check_eq("spur_jobs_done", jobs_done,      32'd1);
        check_eq("spur_cpl_valid", 32'(cpl_valid), 32'd0);
        check_eq("spur_req_ready", 32'(req_ready), 32'd0);

        // ---- reset with START pending and one job outstanding ----
        do_reset();
        start_job(10);
        cycle(1, 11, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 0);
        check_eq("rst_ap_start", 32'(ap_start), 32'd0);
        check_eq("rst_busy",     32'(busy),     32'd0);
        idle();
        start_job(12);
        repeat (6) idle();
        cycle(0, 0, 0, 1, 1, 1);
        check_eq("rst_fresh_id",      32'(cpl_id),     32'd12);
        check_eq("rst_fresh_latency", 32'(cpl_cycles), 32'd7);

        // ---- latency across timestamp wrap ----
        do_reset();
        repeat (250) idle();
        start_job(13);
        repeat (14) idle();
        cycle(0, 0, 0, 1, 1, 1);
        check_eq("wrap_latency", 32'(cpl_cycles), 32'd15);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
